pong_renderer: RTL and testbench

PONG_RENDERER -- requirements
Module: pong_renderer

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_if.sv | 27 ++
 rtl/pong_rect_hit.sv | 21 ++
 rtl/pong_renderer.sv | 109 ++++++++++
 tb/tb_pong_renderer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong renderer.
// Coordinates are widened before comparison so objects clip instead of wrapping.
package pong_pkg;

    typedef logic [11:0] coord_t;
    typedef logic [11:0] color_t;
    typedef logic [13:0] wide_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } pos_t;

    localparam int     DEF_PLAY_X0    = 145;
    localparam int     DEF_PLAY_X1    = 654;
    localparam int     DEF_PLAY_Y0    = 173;
    localparam int     DEF_PLAY_Y1    = 426;
    localparam color_t DEF_OBJ_COLOR  = 12'hFFF;
    localparam color_t DEF_PLAY_COLOR = 12'h000;

    function automatic wide_t widen(input coord_t c);
        return {2'b00, c};
    endfunction

endpackage

// File: rtl/pong_if.sv
// Pixel-scan and game-state bundle between video timing/game logic and the renderer.
interface pong_if #(
    parameter int NUM_PADDLES = 2
);
    logic [10:0]               CurrentX;
    logic [10:0]               CurrentY;
    logic                      VBlank;
    logic                      HBlank;
    logic [24*NUM_PADDLES-1:0] PPositions;
    logic [23:0]               BPosition;
    logic [11:0]               border;
    logic                      serve;
    logic [3:0]                RED;
    logic [3:0]                GREEN;
    logic [3:0]                BLUE;
    logic [7:0]                frame_cnt;

    modport master (
        output CurrentX, CurrentY, VBlank, HBlank, PPositions, BPosition, border, serve,
        input  RED, GREEN, BLUE, frame_cnt
    );

    modport slave (
        input  CurrentX, CurrentY, VBlank, HBlank, PPositions, BPosition, border, serve,
        output RED, GREEN, BLUE, frame_cnt
    );
endinterface

// File: rtl/pong_rect_hit.sv
// Combinational inclusive-rectangle hit test with a W x H box anchored at i_org.
module pong_rect_hit
    import pong_pkg::*;
#(
    parameter int W = 1,
    parameter int H = 1
) (
    input  coord_t i_x,
    input  coord_t i_y,
    input  pos_t   i_org,
    output logic   o_hit
);
    wide_t w_x_hi;
    wide_t w_y_hi;

    assign w_x_hi = widen(i_org.x) + wide_t'(W - 1);
    assign w_y_hi = widen(i_org.y) + wide_t'(H - 1);

    assign o_hit = (widen(i_x) >= widen(i_org.x)) && (widen(i_x) <= w_x_hi) &&
                   (widen(i_y) >= widen(i_org.y)) && (widen(i_y) <= w_y_hi);
endmodule

// File: rtl/pong_renderer.sv
// Two-stage pong pixel renderer: hit flags, then colour. Positions are shadowed per frame.
// Define PONG_BLINK_EN to blink the ball while serving.
module pong_renderer
    import pong_pkg::*;
#(
    parameter int     NUM_PADDLES = 2,
    parameter int     PADDLE_W    = 1,
    parameter int     PADDLE_H    = 28,
    parameter int     BALL_R      = 2,
    parameter int     PLAY_X0     = DEF_PLAY_X0,
    parameter int     PLAY_X1     = DEF_PLAY_X1,
    parameter int     PLAY_Y0     = DEF_PLAY_Y0,
    parameter int     PLAY_Y1     = DEF_PLAY_Y1,
    parameter color_t OBJ_COLOR   = DEF_OBJ_COLOR,
    parameter color_t PLAY_COLOR  = DEF_PLAY_COLOR,
    parameter int     BLINK_LOG2  = 4
) (
    input logic  CLK_100MHz,
    input logic  RESET,
    pong_if.slave bus
);
    localparam pos_t PLAY_ORG = {coord_t'(PLAY_Y0), coord_t'(PLAY_X0)};

    logic                         r_vblank_prev;
    logic [7:0]                   r_frame_cnt;
    pos_t [NUM_PADDLES-1:0]       r_pad_sh;
    pos_t                         r_ball_sh;
    logic                         r_pad_any, r_ball, r_play, r_blank;
    color_t                       r_border, r_color;

    logic                         w_vblank_rise;
    coord_t                       w_x, w_y;
    logic [NUM_PADDLES-1:0]       w_pad_hit;
    logic                         w_play_hit, w_ball_hit, w_ball_vis;
    logic signed [13:0]           w_dy;
    wide_t                        w_d, w_bx_lo, w_bx_hi;

    assign w_x           = {1'b0, bus.CurrentX};
    assign w_y           = {1'b0, bus.CurrentY};
    assign w_vblank_rise = bus.VBlank & ~r_vblank_prev;

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pad
        pong_rect_hit #(.W(PADDLE_W), .H(PADDLE_H)) u_pad_hit (
            .i_x(w_x), .i_y(w_y), .i_org(r_pad_sh[g]), .o_hit(w_pad_hit[g])
        );
    end

    pong_rect_hit #(.W(PLAY_X1 - PLAY_X0 + 1), .H(PLAY_Y1 - PLAY_Y0 + 1)) u_play_hit (
        .i_x(w_x), .i_y(w_y), .i_org(PLAY_ORG), .o_hit(w_play_hit)
    );

    // Diamond: row offset d narrows the span symmetrically from both ends.
    assign w_dy       = $signed(widen(w_y)) - $signed(widen(r_ball_sh.y));
    assign w_d        = w_dy[13] ? wide_t'(-w_dy) : wide_t'(w_dy);
    assign w_bx_lo    = widen(r_ball_sh.x) + w_d;
    assign w_bx_hi    = widen(r_ball_sh.x) + wide_t'(2 * BALL_R + 1) - w_d;
    assign w_ball_hit = (w_d <= wide_t'(BALL_R)) &&
                        (widen(w_x) >= w_bx_lo) && (widen(w_x) <= w_bx_hi);

`ifdef PONG_BLINK_EN
    assign w_ball_vis = ~bus.serve | ~r_frame_cnt[BLINK_LOG2-1];
`else
    // serve has no effect in this build
    assign w_ball_vis = 1'b1 | bus.serve;
`endif

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            r_vblank_prev <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_pad_sh      <= '0;
            r_ball_sh     <= '0;
        end else begin
            r_vblank_prev <= bus.VBlank;
            if (w_vblank_rise) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_pad_sh    <= bus.PPositions;
                r_ball_sh   <= bus.BPosition;
            end
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            r_pad_any <= 1'b0;
            r_ball    <= 1'b0;
            r_play    <= 1'b0;
            r_blank   <= 1'b0;
            r_border  <= '0;
            r_color   <= '0;
        end else begin
            r_pad_any <= |w_pad_hit;
            r_ball    <= w_ball_hit & w_ball_vis;
            r_play    <= w_play_hit;
            r_blank   <= bus.VBlank | bus.HBlank;
            r_border  <= bus.border;
            if (r_blank)        r_color <= '0;
            else if (r_pad_any) r_color <= OBJ_COLOR;
            else if (r_ball)    r_color <= OBJ_COLOR;
            else if (r_play)    r_color <= PLAY_COLOR;
            else                r_color <= r_border;
        end
    end

    assign bus.RED       = r_color[11:8];
    assign bus.GREEN     = r_color[7:4];
    assign bus.BLUE      = r_color[3:0];
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer with hand-computed pixel colours.
module tb_pong_renderer;
    import pong_pkg::*;

`ifdef PONG_BLINK_EN
    localparam logic [11:0] BLINK_OFF_EXP = 12'h000;
`else
    localparam logic [11:0] BLINK_OFF_EXP = 12'hFFF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] w_rgb;
    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_frames = 0;

    always #5 clk = ~clk;

    pong_if #(.NUM_PADDLES(2)) bus ();

    pong_renderer dut (
        .CLK_100MHz(clk),
        .RESET     (rst),
        .bus       (bus)
    );

    assign w_rgb = {bus.RED, bus.GREEN, bus.BLUE};

    function automatic logic [23:0] P(input int x, input int y);
        return {12'(y), 12'(x)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic hb, input logic [11:0] exp,
                       input string tag);
        @(negedge clk);
        bus.CurrentX = 11'(x);
        bus.CurrentY = 11'(y);
        bus.HBlank   = hb;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, 32'(w_rgb), 32'(exp));
    endtask

    task automatic frame(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] ball);
        @(negedge clk);
        bus.PPositions = {p1, p0};
        bus.BPosition  = ball;
        bus.VBlank     = 1'b1;
        @(negedge clk);
        bus.VBlank = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
    endtask

    initial begin
        rst            = 1'b1;
        bus.CurrentX   = '0;
        bus.CurrentY   = '0;
        bus.VBlank     = 1'b0;
        bus.HBlank     = 1'b0;
        bus.PPositions = '0;
        bus.BPosition  = '0;
        bus.border     = 12'hA5C;
        bus.serve      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(w_rgb), 32'h0);
        chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);

        @(negedge clk);
        rst            = 1'b0;
        bus.PPositions = {P(600, 600), P(150, 200)};
        bus.BPosition  = P(400, 300);
        // shadows still zero: paddles sit at the origin until the first VBlank
        pix(0, 5, 1'b0, 12'hFFF, "pre_latch_origin_paddle");
        pix(150, 200, 1'b0, 12'h000, "pre_latch_no_paddle");

        frame(P(150, 200), P(600, 600), P(400, 300));
        chk("frame_cnt_1", 32'(bus.frame_cnt), 32'(exp_frames));

        for (int y = 200; y <= 227; y++) pix(150, y, 1'b0, 12'hFFF, "paddle_scan");
        pix(150, 228, 1'b0, 12'h000, "paddle_below");
        pix(151, 200, 1'b0, 12'h000, "paddle_right");

        pix(400, 300, 1'b0, 12'hFFF, "ball_left");
        pix(405, 300, 1'b0, 12'hFFF, "ball_right");
        pix(402, 298, 1'b0, 12'hFFF, "ball_top");
        pix(403, 302, 1'b0, 12'hFFF, "ball_bottom");
        pix(401, 298, 1'b0, 12'h000, "ball_top_outside");
        pix(406, 300, 1'b0, 12'h000, "ball_right_outside");
        pix(400, 301, 1'b0, 12'h000, "ball_row1_outside");

        pix(10, 10, 1'b0, 12'hA5C, "border");
        pix(150, 200, 1'b1, 12'h000, "hblank");

        @(negedge clk);
        bus.BPosition = P(500, 350);
        pix(400, 300, 1'b0, 12'hFFF, "old_ball_kept");
        pix(500, 350, 1'b0, 12'h000, "new_ball_not_yet");
        frame(P(502, 349), P(600, 600), P(500, 350));
        pix(400, 300, 1'b0, 12'h000, "old_ball_gone");
        pix(500, 350, 1'b0, 12'hFFF, "new_ball_drawn");
        pix(502, 350, 1'b0, 12'hFFF, "paddle_over_ball");

        frame(P(30, 4090), P(600, 600), P(20, 1));
        pix(20, 1, 1'b0, 12'hFFF, "ball_y1_centre");
        pix(21, 0, 1'b0, 12'hFFF, "ball_y1_row0");
        pix(20, 0, 1'b0, 12'hA5C, "ball_y1_row0_left");
        pix(21, 2047, 1'b0, 12'hA5C, "ball_y1_no_wrap");
        pix(30, 5, 1'b0, 12'hA5C, "paddle_no_wrap");
        frame(P(150, 200), P(600, 600), P(40, 4094));
        pix(42, 0, 1'b0, 12'hA5C, "ball_bottom_no_wrap");

        @(negedge clk);
        bus.serve = 1'b1;
        while (exp_frames != 7) frame(P(150, 200), P(600, 600), P(400, 300));
        pix(400, 300, 1'b0, 12'hFFF, "serve_frame7");
        frame(P(150, 200), P(600, 600), P(400, 300));
        chk("frame_cnt_8", 32'(bus.frame_cnt), 32'(exp_frames));
        pix(400, 300, 1'b0, BLINK_OFF_EXP, "serve_frame8");
        @(negedge clk);
        bus.serve = 1'b0;
        pix(400, 300, 1'b0, 12'hFFF, "no_serve_frame8");
        @(negedge clk);
        bus.serve = 1'b1;
        while (exp_frames != 16) frame(P(150, 200), P(600, 600), P(400, 300));
        pix(400, 300, 1'b0, 12'hFFF, "serve_frame16");

        while (exp_frames != 255) frame(P(150, 200), P(600, 600), P(400, 300));
        chk("frame_cnt_255", 32'(bus.frame_cnt), 32'd255);
        frame(P(150, 200), P(600, 600), P(400, 300));
        chk("frame_cnt_wrap", 32'(bus.frame_cnt), 32'd0);

        @(negedge clk);
        bus.serve = 1'b0;
        pix(400, 300, 1'b0, 12'hFFF, "pre_reset_ball");
        @(negedge clk);
        rst          = 1'b1;
        bus.CurrentX = 11'd10;
        bus.CurrentY = 11'd10;
        @(posedge clk);
        #1;
        chk("mid_reset_rgb", 32'(w_rgb), 32'h0);
        chk("mid_reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_cycle1", 32'(w_rgb), 32'h0);
        @(posedge clk);
        #1;
        chk("post_reset_cycle2", 32'(w_rgb), 32'hA5C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
